// File: rtl/fs_pkg.sv
// Shared constants and state encoding for the bit-serial full subtractor.
package fs_pkg;

    localparam int unsigned FS_WIDTH = 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    typedef enum logic [1:0] {
        StIdle  = S_IDLE,
        StShift = S_SHIFT,
        StDone  = S_DONE
    } fs_state_e;

endpackage

// File: rtl/fs_1bit.sv
// Combinational full-subtractor cell: d = x - y - bin, with borrow-out.
module fs_1bit (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/fs_serial.sv
// Bit-serial full subtractor (a - b - bin), LSB first, one bit per clock.
// Optional signed-overflow flag enabled by defining FS_SERIAL_OVF_EN.
module fs_serial
    import fs_pkg::*;
#(
    parameter int unsigned WIDTH = FS_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy,
`ifdef FS_SERIAL_OVF_EN
    output logic             ovf,
`endif
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH);

    fs_state_e        state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             br_q;
    logic [CW-1:0]    cnt_q;
    logic             bit_d;
    logic             bit_b;

    // Operands shift right each cycle so the cell always sees the current bit at [0].
    fs_1bit u_cell (
        .x    (a_q[0]),
        .y    (b_q[0]),
        .bin  (br_q),
        .d    (bit_d),
        .bout (bit_b)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= StIdle;
            a_q   <= '0;
            b_q   <= '0;
            br_q  <= 1'b0;
            cnt_q <= '0;
            diff  <= '0;
            bout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef FS_SERIAL_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                StIdle: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        br_q  <= bin;
                        cnt_q <= '0;
                        busy  <= 1'b1;
                        state <= StShift;
                    end
                end
                StShift: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    br_q  <= bit_b;
                    diff  <= {bit_d, diff[WIDTH-1:1]};
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        bout  <= bit_b;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= StDone;
`ifdef FS_SERIAL_OVF_EN
                        ovf   <= (a_q[0] ^ b_q[0]) & (a_q[0] ^ bit_d);
`endif
                    end
                end
                StDone: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        br_q  <= bin;
                        cnt_q <= '0;
                        busy  <= 1'b1;
                        state <= StShift;
                    end else begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fs_serial.sv
// Directed self-checking bench for fs_serial (WIDTH = 4).
module tb_fs_serial;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] diff;
    logic         bout;
    logic         busy;
    logic         done;
`ifdef FS_SERIAL_OVF_EN
    logic         ovf;
`endif

    int vectors = 0;
    int miscompares = 0;

    fs_serial #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .diff  (diff),
        .bout  (bout),
        .busy  (busy),
`ifdef FS_SERIAL_OVF_EN
        .ovf   (ovf),
`endif
        .done  (done)
    );

    always #5 clk = ~clk;

    // Hand-computed vectors: a, b, bin -> diff, bout, ovf
    logic [W-1:0] va [9] = '{4'b1111, 4'b1111, 4'b1000, 4'b1000, 4'b0000, 4'b0000,
                             4'b0101, 4'b0011, 4'b0111};
    logic [W-1:0] vb [9] = '{4'b1000, 4'b1000, 4'b0111, 4'b0111, 4'b0001, 4'b0001,
                             4'b0101, 4'b0101, 4'b1111};
    logic         vi [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [W-1:0] vd [9] = '{4'b0111, 4'b0110, 4'b0001, 4'b0000, 4'b1111, 4'b1110,
                             4'b0000, 4'b1101, 4'b1000};
    logic         vo [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic         vv [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Drive a start pulse; returns #1 after the accepting edge.
    task automatic accept_start(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                input logic tbin, input logic keep);
        @(negedge clk);
        a = ta;
        b = tb;
        bin = tbin;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!keep) start = 1'b0;
        a = ~ta;
        b = ~tb;
        bin = ~tbin;
    endtask

    // Counts edges until done is seen; -1 on timeout.
    task automatic wait_done(input int max_cyc, output int n);
        n = -1;
        for (int i = 1; i <= max_cyc; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        a = 4'b1111;
        b = 4'b0001;
        bin = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({busy, done, diff, bout} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset: busy/done/diff/bout got %b want 0000000",
                     {busy, done, diff, bout});
        end
`ifdef FS_SERIAL_OVF_EN
        vectors++;
        if (ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ovf: got %b want 0", ovf);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({busy, done} !== 2'b00) begin
            miscompares++;
            $display("FAIL idle_after_reset: busy/done got %b want 00", {busy, done});
        end
    endtask

    task automatic test_vectors;
        int n;
        for (int i = 0; i < 9; i++) begin
            accept_start(va[i], vb[i], vi[i], 1'b0);
            vectors++;
            if (busy !== 1'b1) begin
                miscompares++;
                $display("FAIL vec%0d busy_after_start: got %b want 1", i, busy);
            end
            wait_done(10, n);
            vectors++;
            if (n !== W) begin
                miscompares++;
                $display("FAIL vec%0d latency: got %0d want %0d", i, n, W);
            end
            vectors++;
            if ({busy, diff, bout} !== {1'b0, vd[i], vo[i]}) begin
                miscompares++;
                $display("FAIL vec%0d result: busy/diff/bout got %b %b %b want 0 %b %b",
                         i, busy, diff, bout, vd[i], vo[i]);
            end
`ifdef FS_SERIAL_OVF_EN
            vectors++;
            if (ovf !== vv[i]) begin
                miscompares++;
                $display("FAIL vec%0d ovf: got %b want %b", i, ovf, vv[i]);
            end
`endif
            @(posedge clk);
            #1;
            vectors++;
            if ({done, diff, bout} !== {1'b0, vd[i], vo[i]}) begin
                miscompares++;
                $display("FAIL vec%0d hold: done/diff/bout got %b %b %b want 0 %b %b",
                         i, done, diff, bout, vd[i], vo[i]);
            end
        end
    endtask

    task automatic test_ignore_start;
        int n;
        int extra;
        accept_start(4'b0101, 4'b0011, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        a = 4'b1111;
        b = 4'b1111;
        bin = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL ignore busy: got %b want 1", busy);
        end
        wait_done(10, n);
        vectors++;
        if (n !== W - 2) begin
            miscompares++;
            $display("FAIL ignore latency: got %0d want %0d", n, W - 2);
        end
        vectors++;
        if ({diff, bout} !== {4'b0010, 1'b0}) begin
            miscompares++;
            $display("FAIL ignore result: diff/bout got %b %b want 0010 0", diff, bout);
        end
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        vectors++;
        if (extra !== 0) begin
            miscompares++;
            $display("FAIL ignore extra_activity: got %0d cycles want 0", extra);
        end
    endtask

    task automatic test_reset_mid;
        int pulses;
        int n;
        accept_start(4'b1010, 4'b0011, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if ({busy, done, diff, bout} !== 7'b0) begin
            miscompares++;
            $display("FAIL midreset: busy/done/diff/bout got %b want 0000000",
                     {busy, done, diff, bout});
        end
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) pulses++;
        end
        vectors++;
        if (pulses !== 0) begin
            miscompares++;
            $display("FAIL midreset done_pulses: got %0d want 0", pulses);
        end
        accept_start(4'b1010, 4'b0011, 1'b0, 1'b0);
        wait_done(10, n);
        vectors++;
        if ({n == W, diff, bout} !== {1'b1, 4'b0111, 1'b0}) begin
            miscompares++;
            $display("FAIL midreset rerun: cycles/diff/bout got %0d %b %b want %0d 0111 0",
                     n, diff, bout, W);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        time t1;
        time t2;
        accept_start(4'b1111, 4'b1000, 1'b0, 1'b1);
        a = 4'b1000;
        b = 4'b0111;
        bin = 1'b1;
        wait_done(10, n);
        t1 = $time;
        vectors++;
        if ({n == W, diff, bout} !== {1'b1, 4'b0111, 1'b0}) begin
            miscompares++;
            $display("FAIL b2b first: cycles/diff/bout got %0d %b %b want %0d 0111 0",
                     n, diff, bout, W);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        vectors++;
        if ({busy, done} !== 2'b10) begin
            miscompares++;
            $display("FAIL b2b restart: busy/done got %b want 10", {busy, done});
        end
        wait_done(10, n);
        t2 = $time;
        vectors++;
        if (t2 - t1 !== 64'd50) begin
            miscompares++;
            $display("FAIL b2b spacing: got %0t want 50", t2 - t1);
        end
        vectors++;
        if ({diff, bout} !== {4'b0000, 1'b0}) begin
            miscompares++;
            $display("FAIL b2b second: diff/bout got %b %b want 0000 0", diff, bout);
        end
`ifdef FS_SERIAL_OVF_EN
        vectors++;
        if (ovf !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b ovf: got %b want 1", ovf);
        end
`endif
    endtask

    initial begin
        test_reset;
        test_vectors;
        test_ignore_start;
        test_reset_mid;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
